// File: rtl/pzbcm_fifo_reader.sv
// Show-ahead FIFO read adapter: pops the FIFO into a 2-entry skid buffer
// and presents a valid/ready stream. Define PZBCM_FIFO_READER_COUNT_EN to add o_count.
module pzbcm_fifo_reader #(
  parameter int  WIDTH       = 8,
  parameter type TYPE        = logic [WIDTH-1:0],
  parameter int  COUNT_WIDTH = 16
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_empty,
  output logic o_pop,
  input  TYPE  i_data,
  output logic o_valid,
  input  logic i_ready,
  output TYPE  o_data
`ifdef PZBCM_FIFO_READER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state;
  TYPE    head;
  TYPE    tail;
  logic   valid;
  logic   push;
  logic   pull;

  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("COUNT_WIDTH must be at least 1");
  end

  // The pop decision looks only at registered state and FIFO/clear inputs,
  // so downstream ready never reaches o_pop combinationally.
  assign o_pop = i_rst_n && !i_empty && !i_clear && (state != TWO);
  assign push  = o_pop;
  assign pull  = valid && i_ready;

  // NOTE: state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of head/tail/state, which the head <= tail shift relies on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else if (i_clear) begin
      state <= EMPTY;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state <= ONE;
            valid <= 1'b1;
            head  <= i_data;
          end
        end
        ONE: begin
          if (push && !pull) begin
            state <= TWO;
            tail  <= i_data;
          end else if (!push && pull) begin
            state <= EMPTY;
            valid <= 1'b0;
          end else if (push && pull) begin
            head  <= i_data;
          end
        end
        TWO: begin
          if (pull) begin
            state <= ONE;
            head  <= tail;
          end
        end
        default: begin
          state <= EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid;
  assign o_data  = head;

`ifdef PZBCM_FIFO_READER_COUNT_EN
  logic [COUNT_WIDTH-1:0] count;

  // Counts every downstream handshake; flushes do not rewind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (pull) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  assign o_count = count;
`endif

endmodule

// File: tb/tb_pzbcm_fifo_reader.sv
// Directed bench for pzbcm_fifo_reader with a queue-based show-ahead FIFO model.
// The o_count section runs only when PZBCM_FIFO_READER_COUNT_EN is defined.
module tb_pzbcm_fifo_reader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_clear;
  logic       i_empty;
  logic       o_pop;
  logic [7:0] i_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
`ifdef PZBCM_FIFO_READER_COUNT_EN
  logic [1:0] o_count;
`endif

  int         errors = 0;
  int         checks = 0;
  int         pops   = 0;
  logic [7:0] fifo[$];
  logic [7:0] rx[$];

  always #5 i_clk = ~i_clk;

  pzbcm_fifo_reader #(
    .WIDTH       (8),
    .COUNT_WIDTH (2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_empty (i_empty),
    .o_pop   (o_pop),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef PZBCM_FIFO_READER_COUNT_EN
    ,
    .o_count (o_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the model FIFO head to the DUT and let o_pop settle.
  task automatic drive_fifo();
    i_empty = (fifo.size() == 0);
    i_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    #1;
  endtask

  // One clock: note the pop and any handshake before the edge, then update the model.
  task automatic cycle();
    logic p;
    p = o_pop;
    if (o_valid && i_ready && !i_clear) rx.push_back(o_data);
    @(posedge i_clk);
    @(negedge i_clk);
    if (p) begin
      pops++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    drive_fifo();
  endtask

  initial begin
    logic [7:0] exp_a[4];
    logic [7:0] exp_cnt[5];
    int         nhs;
    logic       hs;
    exp_a   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

    // Reset with empty FIFO
    i_rst_n = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    drive_fifo();
    repeat (2) @(negedge i_clk);
    #1;
    check("reset_pop",   32'(o_pop),   32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_data",  32'(o_data),  32'h0);
    i_rst_n = 1'b1;
    #1;
    cycle();
    check("idle_pop",   32'(o_pop),   32'h0);
    check("idle_valid", 32'(o_valid), 32'h0);

    // Streaming 0x11,0x22,0x33 with ready held high
    fifo = '{8'h11, 8'h22, 8'h33};
    i_ready = 1'b1;
    pops = 0;
    rx.delete();
    drive_fifo();
    check("s_pop0",   32'(o_pop),   32'h1);
    check("s_valid0", 32'(o_valid), 32'h0);
    cycle();
    check("s_valid1", 32'(o_valid), 32'h1);
    check("s_data1",  32'(o_data),  32'h11);
    check("s_pop1",   32'(o_pop),   32'h1);
    cycle();
    check("s_valid2", 32'(o_valid), 32'h1);
    check("s_data2",  32'(o_data),  32'h22);
    check("s_pop2",   32'(o_pop),   32'h1);
    cycle();
    check("s_valid3", 32'(o_valid), 32'h1);
    check("s_data3",  32'(o_data),  32'h33);
    check("s_pop3",   32'(o_pop),   32'h0);
    cycle();
    check("s_valid4", 32'(o_valid), 32'h0);
    check("s_pops",   32'(pops),    32'd3);
    check("s_rxn",    32'(rx.size()), 32'd3);

    // Backpressure: 4 words, ready low -> buffer fills to two and stalls
    i_ready = 1'b0;
    fifo = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    pops = 0;
    drive_fifo();
    repeat (4) cycle();
    check("bp_pops",  32'(pops),        32'd2);
    check("bp_valid", 32'(o_valid),     32'h1);
    check("bp_data",  32'(o_data),      32'hA0);
    check("bp_pop",   32'(o_pop),       32'h0);
    check("bp_left",  32'(fifo.size()), 32'd2);
    i_ready = 1'b1;
    rx.delete();
    #1;
    repeat (5) cycle();
    check("bp_rxn", 32'(rx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) check($sformatf("bp_rx%0d", i), 32'(rx[i]), 32'(exp_a[i]));
    end
    check("bp_valid_end", 32'(o_valid), 32'h0);
    check("bp_pops_end",  32'(pops),    32'd4);

    // Clear while holding two words, with ready high
    i_ready = 1'b0;
    fifo = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    drive_fifo();
    repeat (2) cycle();
    check("cl_data_pre", 32'(o_data), 32'hB0);
    i_ready = 1'b1;
    i_clear = 1'b1;
    #1;
    check("cl_pop", 32'(o_pop), 32'h0);
    cycle();
    check("cl_valid", 32'(o_valid), 32'h0);
    i_clear = 1'b0;
    #1;
    check("cl_pop_after", 32'(o_pop), 32'h1);
    rx.delete();
    cycle();
    check("cl_valid_next", 32'(o_valid), 32'h1);
    check("cl_data_next",  32'(o_data),  32'hB2);
    repeat (3) cycle();
    check("cl_rxn", 32'(rx.size()), 32'd2);
    if (rx.size() == 2) begin
      check("cl_rx0", 32'(rx[0]), 32'hB2);
      check("cl_rx1", 32'(rx[1]), 32'hB3);
    end

    // Reset mid-transfer: buffered words dropped, no pops during reset
    i_ready = 1'b0;
    fifo = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    drive_fifo();
    repeat (2) cycle();
    i_rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(o_valid), 32'h0);
    check("mr_data",  32'(o_data),  32'h0);
    check("mr_pop",   32'(o_pop),   32'h0);
    cycle();
    check("mr_left", 32'(fifo.size()), 32'd2);
    i_rst_n = 1'b1;
    #1;
    check("mr_resume_pop", 32'(o_pop), 32'h1);
    i_ready = 1'b1;
    rx.delete();
    #1;
    repeat (4) cycle();
    check("mr_rxn", 32'(rx.size()), 32'd2);
    if (rx.size() == 2) begin
      check("mr_rx0", 32'(rx[0]), 32'hC2);
      check("mr_rx1", 32'(rx[1]), 32'hC3);
    end

`ifdef PZBCM_FIFO_READER_COUNT_EN
    // Handshake counter, 2 bits wide: 1,2,3,0,1 and immune to clear
    i_rst_n = 1'b0;
    #1;
    check("cnt_reset", 32'(o_count), 32'h0);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    fifo = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    drive_fifo();
    nhs = 0;
    repeat (7) begin
      hs = o_valid && i_ready;
      cycle();
      if (hs) begin
        if (nhs < 5) check($sformatf("cnt_seq%0d", nhs), 32'(o_count), 32'(exp_cnt[nhs]));
        nhs++;
      end
    end
    check("cnt_nhs", 32'(nhs), 32'd5);
    i_ready = 1'b0;
    fifo = '{8'hE0};
    drive_fifo();
    repeat (2) cycle();
    check("cnt_hold_valid", 32'(o_valid), 32'h1);
    i_clear = 1'b1;
    #1;
    cycle();
    i_clear = 1'b0;
    #1;
    check("cnt_after_clear", 32'(o_count), 32'h1);
    check("cnt_clear_valid", 32'(o_valid), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
